// File: rtl/db_nb_buf_ctrl.sv
// Deblocking neighbour-buffer client: per MB, reads the 4 words stored for column mb_x
// (left by the MB row above), then overwrites them with the current MB's 4 words.
module db_nb_buf_ctrl #(
  parameter int WORD_W   = 28,
  parameter int ADDR_W   = 9,
  parameter int MBX_W    = 7,
  parameter int MAX_MB_X = 119
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic [MBX_W-1:0]    mb_x_i,
  input  logic                first_row_i,
  input  logic [4*WORD_W-1:0] wr_data_i,
  output logic [4*WORD_W-1:0] rd_data_o,
  output logic                rd_valid_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o,
  output logic                ram_cen_o,
  output logic                ram_oen_o,
  output logic                ram_wen_o,
  output logic [ADDR_W-1:0]   ram_addr_o,
  output logic [WORD_W-1:0]   ram_data_o,
  input  logic [WORD_W-1:0]   ram_data_i
);

  // Handshake: start_i is a single-cycle request, taken only while busy_o=0;
  // done_o pulses once per taken request, and rd_data_o/rd_valid_o hold until the next one.
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t              state_q, state_nxt;
  logic [1:0]          k_q, k_nxt;
  logic [MBX_W-1:0]    mb_x_q, mb_x_use;
  logic [4*WORD_W-1:0] wr_data_q, wr_data_use;
  logic                read_q;
  logic                accept, bad_mb, access_nxt;
  logic [ADDR_W-1:0]   addr_nxt;
  logic [WORD_W-1:0]   wr_word_nxt;
  logic [1:0]          k_rd;

  assign accept = start_i && (state_q == IDLE);
  assign bad_mb = int'(mb_x_i) > MAX_MB_X;

  always_comb begin
    state_nxt = state_q;
    k_nxt     = k_q;
    case (state_q)
      IDLE: begin
        k_nxt = 2'd0;
        if (start_i) begin
          if (bad_mb)           state_nxt = DONE;
          else if (first_row_i) state_nxt = WRITE;
          else                  state_nxt = READ;
        end
      end
      READ: begin
        k_nxt = k_q + 2'd1;
        if (k_q == 2'd3) state_nxt = WRITE;
      end
      WRITE: begin
        k_nxt = k_q + 2'd1;
        if (k_q == 2'd3) state_nxt = DONE;
      end
      DONE: begin
        k_nxt     = 2'd0;
        state_nxt = IDLE;
      end
      default: begin
        k_nxt     = 2'd0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= 2'd0;
    end else begin
      state_q <= state_nxt;
      k_q     <= k_nxt;
    end
  end

  // RAM port values are derived from the state being entered, so they are registered
  // yet line up with that state's cycle.
  assign mb_x_use    = accept ? mb_x_i : mb_x_q;
  assign wr_data_use = accept ? wr_data_i : wr_data_q;
  assign access_nxt  = (state_nxt == READ) || (state_nxt == WRITE);
  assign addr_nxt    = (ADDR_W'(mb_x_use) << 2) + ADDR_W'(k_nxt);
  assign wr_word_nxt = wr_data_use[k_nxt*WORD_W +: WORD_W];
  assign k_rd        = k_q - 2'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      mb_x_q     <= '0;
      wr_data_q  <= '0;
      read_q     <= 1'b0;
      rd_data_o  <= '0;
      rd_valid_o <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      err_o      <= 1'b0;
      ram_cen_o  <= 1'b1;
      ram_oen_o  <= 1'b1;
      ram_wen_o  <= 1'b1;
      ram_addr_o <= '0;
      ram_data_o <= '0;
    end else begin
      busy_o     <= state_nxt != IDLE;
      done_o     <= state_nxt == DONE;
      err_o      <= accept && bad_mb;
      ram_cen_o  <= !access_nxt;
      ram_oen_o  <= state_nxt != READ;
      ram_wen_o  <= state_nxt != WRITE;
      ram_addr_o <= access_nxt ? addr_nxt : '0;
      ram_data_o <= (state_nxt == WRITE) ? wr_word_nxt : '0;

      if (accept) begin
        mb_x_q     <= mb_x_i;
        wr_data_q  <= wr_data_i;
        read_q     <= !bad_mb && !first_row_i;
        rd_valid_o <= 1'b0;
        rd_data_o  <= '0;
      end

      // RAM read data trails its access by one cycle; word 3 lands in WRITE k=0.
      if (state_q == READ && k_q != 2'd0)
        rd_data_o[k_rd*WORD_W +: WORD_W] <= ram_data_i;
      if (state_q == WRITE && k_q == 2'd0 && read_q)
        rd_data_o[3*WORD_W +: WORD_W] <= ram_data_i;

      if (state_q == WRITE && k_q == 2'd3)
        rd_valid_o <= read_q;
    end
  end

endmodule
